// File: rtl/vio_route_ctrl.sv
// Runtime route-change controller for the vio switch: a new 14-bit route word is
// committed to a region only after its user stream is held at a packet boundary.
module vio_route_ctrl #(
    parameter int          N_ID           = 8,
    parameter logic [13:0] RST_ROUTE      = 14'h0000,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [3:0]           cfg_region,
    input  logic [13:0]          cfg_route,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic [1:0]           cfg_err_code,
    input  logic [N_ID-1:0]      mon_tvalid,
    input  logic [N_ID-1:0]      mon_tready,
    input  logic [N_ID-1:0]      mon_tlast,
    output logic [N_ID-1:0]      stall,
    output logic [N_ID-1:0]      in_pkt,
    output logic [N_ID-1:0][13:0] route_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       req_region;
    logic [13:0]      req_route;
    logic [N_ID-1:0]  sel;
    logic [N_ID-1:0]  beat;
    logic             bad_region;
    logic             drained;
    logic             timed_out;

    assign beat       = mon_tvalid & mon_tready;
    assign bad_region = {1'b0, cfg_region} >= 5'(N_ID);
    // Safe to switch only when the region is between packets and no beat is in flight now.
    assign drained    = ~|(sel & (in_pkt | beat));
    assign timed_out  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cfg_ready  = (state == IDLE);
    assign stall      = (state == IDLE) ? '0 : sel;

    always_comb begin
        // NOTE: assign a default before the loop so every path drives sel and no latch is inferred.
        sel = '0;
        for (int i = 0; i < N_ID; i++) begin
            sel[i] = (req_region == 4'(i));
        end
    end

    // Packet tracking runs regardless of the FSM: a beat opens or closes the packet.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            in_pkt <= '0;
        end else begin
            in_pkt <= (in_pkt & ~beat) | (beat & ~mon_tlast);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (areset) begin
            state        <= IDLE;
            cnt          <= '0;
            req_region   <= '0;
            req_route    <= '0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            cfg_err_code <= 2'b00;
            route_out    <= {N_ID{RST_ROUTE}};
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        req_region <= cfg_region;
                        req_route  <= cfg_route;
                        if (bad_region) begin
                            cfg_err      <= 1'b1;
                            cfg_err_code <= 2'b01;
                        end else begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (drained) begin
                        state <= APPLY;
                    end else if (timed_out) begin
                        cfg_err      <= 1'b1;
                        cfg_err_code <= 2'b10;
                        state        <= IDLE;
                    end
                end
                APPLY: begin
                    for (int i = 0; i < N_ID; i++) begin
                        if (sel[i]) route_out[i] <= req_route;
                    end
                    cfg_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
